// File: rtl/lock_pkg.sv
// Shared definitions for the lock's feedback path: buzzer source encodings
// and the buzzer sequencer state type.
package lock_pkg;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_KEY  = 2'd1;
  localparam logic [1:0] SRC_OK   = 2'd2;
  localparam logic [1:0] SRC_ALM  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } buzz_state_t;

endpackage

// File: rtl/ms_tick.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 and flags the last count as the
// tick. A synchronous clear restarts the count so that each phase is aligned.
module ms_tick #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (clr || (tick_cnt == LAST)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/buzz_sched.sv
// Piezo buzzer sequencer/arbiter: fixed-priority selection of key click, OK
// chime and alarm, with ms-timed on/off phases. `BUZZ_SCHED_MUTE_EN adds a mute input.
module buzz_sched
  import lock_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned KEY_MS     = 100,
  parameter int unsigned OK_ON_MS   = 200,
  parameter int unsigned OK_OFF_MS  = 200,
  parameter int unsigned OK_BEEPS   = 2,
  parameter int unsigned ALM_ON_MS  = 500,
  parameter int unsigned ALM_OFF_MS = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_req,
  input  logic       ok_req,
  input  logic       alarm_req,
  input  logic       alarm_clr,
`ifdef BUZZ_SCHED_MUTE_EN
  input  logic       mute,
`endif
  output logic       buzz_en,
  output logic       busy,
  output logic [1:0] src,
  output logic       done
);

  localparam logic [15:0] KEY_T     = 16'(KEY_MS);
  localparam logic [15:0] OK_ON_T   = 16'(OK_ON_MS);
  localparam logic [15:0] OK_OFF_T  = 16'(OK_OFF_MS);
  localparam logic [15:0] ALM_ON_T  = 16'(ALM_ON_MS);
  localparam logic [15:0] ALM_OFF_T = 16'(ALM_OFF_MS);
  localparam logic [15:0] BEEPS_T   = 16'(OK_BEEPS);

  buzz_state_t state, state_n;
  logic [15:0] ms_cnt, ms_cnt_n;
  logic [15:0] beeps_left, beeps_n;
  logic [1:0]  src_n;
  logic        done_n;
  logic        buzz_n;
  logic        tick;
  logic        tick_clr;
  logic        mute_i;
  logic [1:0]  req_pri;
  logic        accept;
  logic        clr_alarm;
  logic        phase_end;
  logic [15:0] phase_ms;

`ifdef BUZZ_SCHED_MUTE_EN
  assign mute_i = mute;
`else
  assign mute_i = 1'b0;
`endif

  ms_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_ms_tick (
    .clk (clk),
    .rst (rst),
    .clr (tick_clr),
    .tick(tick)
  );

  // A simultaneous alarm_clr+alarm_req suppresses every request that cycle.
  always_comb begin
    req_pri = SRC_NONE;
    if (alarm_req && alarm_clr) begin
      req_pri = SRC_NONE;
    end else if (alarm_req) begin
      req_pri = SRC_ALM;
    end else if (ok_req && !mute_i) begin
      req_pri = SRC_OK;
    end else if (key_req && !mute_i) begin
      req_pri = SRC_KEY;
    end
  end

  assign accept    = (req_pri > src);
  assign clr_alarm = alarm_clr && (src == SRC_ALM);

  always_comb begin
    phase_ms = KEY_T;
    case (src)
      SRC_OK:  phase_ms = (state == ON) ? OK_ON_T  : OK_OFF_T;
      SRC_ALM: phase_ms = (state == ON) ? ALM_ON_T : ALM_OFF_T;
      default: phase_ms = KEY_T;
    endcase
  end

  assign phase_end = (state != IDLE) && tick && (ms_cnt == (phase_ms - 16'd1));

  always_comb begin
    state_n  = state;
    src_n    = src;
    beeps_n  = beeps_left;
    ms_cnt_n = tick ? (ms_cnt + 16'd1) : ms_cnt;
    done_n   = 1'b0;
    tick_clr = 1'b0;

    if (state == IDLE) begin
      ms_cnt_n = '0;
      tick_clr = 1'b1;
    end

    if (clr_alarm) begin
      state_n  = IDLE;
      src_n    = SRC_NONE;
      beeps_n  = '0;
      ms_cnt_n = '0;
      tick_clr = 1'b1;
      done_n   = 1'b1;
    end else if (accept) begin
      state_n  = ON;
      src_n    = req_pri;
      beeps_n  = (req_pri == SRC_KEY) ? 16'd1 :
                 (req_pri == SRC_OK)  ? BEEPS_T : 16'd0;
      ms_cnt_n = '0;
      tick_clr = 1'b1;
    end else if (phase_end) begin
      ms_cnt_n = '0;
      tick_clr = 1'b1;
      if (state == ON) begin
        if (src == SRC_ALM) begin
          state_n = OFF;
        end else if (beeps_left == 16'd1) begin
          state_n = IDLE;
          src_n   = SRC_NONE;
          beeps_n = '0;
          done_n  = 1'b1;
        end else begin
          state_n = OFF;
          beeps_n = beeps_left - 16'd1;
        end
      end else begin
        state_n = ON;
      end
    end

    buzz_n = (state_n == ON) && !(mute_i && (src_n != SRC_ALM));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ms_cnt     <= '0;
      beeps_left <= '0;
      src        <= SRC_NONE;
      done       <= 1'b0;
      buzz_en    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      ms_cnt     <= ms_cnt_n;
      beeps_left <= beeps_n;
      src        <= src_n;
      done       <= done_n;
      buzz_en    <= buzz_n;
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_buzz_sched.sv
// Scoreboard bench for buzz_sched with a scaled-down tick (TICK_DIV=4);
// stimulus queues the expected per-cycle outputs, a negedge monitor checks them.
module tb_buzz_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_req, ok_req, alarm_req, alarm_clr;
`ifdef BUZZ_SCHED_MUTE_EN
  logic       mute;
`endif
  logic       buzz_en, busy, done;
  logic [1:0] src;

  always #5 clk = ~clk;

  buzz_sched #(
    .TICK_DIV  (4),
    .KEY_MS    (3),
    .OK_ON_MS  (2),
    .OK_OFF_MS (2),
    .OK_BEEPS  (2),
    .ALM_ON_MS (2),
    .ALM_OFF_MS(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_req  (key_req),
    .ok_req   (ok_req),
    .alarm_req(alarm_req),
    .alarm_clr(alarm_clr),
`ifdef BUZZ_SCHED_MUTE_EN
    .mute     (mute),
`endif
    .buzz_en  (buzz_en),
    .busy     (busy),
    .src      (src),
    .done     (done)
  );

  typedef struct {
    string      name;
    int         cyc;
    logic       bz;
    logic       busy;
    logic [1:0] src;
    logic       done;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  int    checks = 0;
  int    errors = 0;
  int    cyc_no = 0;
  string phase  = "reset";

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({buzz_en, busy, src, done} !== {mon_e.bz, mon_e.busy, mon_e.src, mon_e.done}) begin
        errors++;
        $display("FAIL %s cyc %0d: got buzz_en=%b busy=%b src=%0d done=%b, expected buzz_en=%b busy=%b src=%0d done=%b",
                 mon_e.name, mon_e.cyc, buzz_en, busy, src, done,
                 mon_e.bz, mon_e.busy, mon_e.src, mon_e.done);
      end
    end
  end

  task automatic start(input string name);
    phase  = name;
    cyc_no = -1;
  endtask

  task automatic push(input logic bz, input logic bs, input logic [1:0] s, input logic d);
    exp_t e;
    e.name = phase;
    e.cyc  = cyc_no;
    e.bz   = bz;
    e.busy = bs;
    e.src  = s;
    e.done = d;
    exp_q.push_back(e);
  endtask

  // One cycle: expected outputs for this cycle, and request inputs driven during it.
  task automatic cyc(input logic k, input logic o, input logic a, input logic c,
                     input logic bz, input logic bs, input logic [1:0] s, input logic d);
    @(posedge clk);
    #1;
    cyc_no++;
    push(bz, bs, s, d);
    key_req   = k;
    ok_req    = o;
    alarm_req = a;
    alarm_clr = c;
  endtask

  task automatic hold(input int n, input logic bz, input logic bs,
                      input logic [1:0] s, input logic d);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, bz, bs, s, d);
  endtask

  initial begin
    rst = 1'b1;
    key_req = 1'b0; ok_req = 1'b0; alarm_req = 1'b0; alarm_clr = 1'b0;
`ifdef BUZZ_SCHED_MUTE_EN
    mute = 1'b0;
`endif

    start("reset");
    hold(3, 0, 0, 0, 0);
    rst = 1'b0;
    hold(2, 0, 0, 0, 0);

    // Key click with an equal-priority repeat that must not restart it.
    start("key");
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    hold(3, 1, 1, 1, 0);
    cyc(1, 0, 0, 0, 1, 1, 1, 0);
    hold(8, 1, 1, 1, 0);
    hold(1, 0, 0, 0, 1);
    hold(2, 0, 0, 0, 0);

    start("ok");
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    hold(8, 1, 1, 2, 0);
    hold(8, 0, 1, 2, 0);
    hold(8, 1, 1, 2, 0);
    hold(1, 0, 0, 0, 1);
    hold(1, 0, 0, 0, 0);

    // OK request on the key's final edge preempts without a done pulse;
    // a key request during the OK gap is dropped.
    start("end_edge");
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    hold(11, 1, 1, 1, 0);
    cyc(0, 1, 0, 0, 1, 1, 1, 0);
    hold(8, 1, 1, 2, 0);
    hold(2, 0, 1, 2, 0);
    cyc(1, 0, 0, 0, 0, 1, 2, 0);
    hold(5, 0, 1, 2, 0);
    hold(8, 1, 1, 2, 0);
    hold(1, 0, 0, 0, 1);
    hold(1, 0, 0, 0, 0);

    start("preempt");
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    hold(4, 1, 1, 1, 0);
    cyc(0, 0, 1, 0, 1, 1, 1, 0);
    hold(4, 1, 1, 3, 0);
    cyc(0, 1, 0, 0, 1, 1, 3, 0);
    hold(3, 1, 1, 3, 0);
    hold(4, 0, 1, 3, 0);
    hold(8, 1, 1, 3, 0);
    hold(4, 0, 1, 3, 0);
    hold(2, 1, 1, 3, 0);
    cyc(0, 0, 1, 1, 1, 1, 3, 0);
    hold(1, 0, 0, 0, 1);
    hold(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    hold(3, 0, 0, 0, 0);

    // All three requests at once, then asynchronous reset in mid-ON.
    start("rst");
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    hold(2, 1, 1, 3, 0);
    @(posedge clk);
    #1;
    cyc_no++;
    push(0, 0, 0, 0);
    key_req = 1'b0; ok_req = 1'b0; alarm_req = 1'b0; alarm_clr = 1'b0;
    rst = 1'b1;
    hold(2, 0, 0, 0, 0);
    rst = 1'b0;
    hold(5, 0, 0, 0, 0);

`ifdef BUZZ_SCHED_MUTE_EN
    start("mute");
    mute = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    hold(3, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    hold(2, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    hold(8, 1, 1, 3, 0);
    hold(4, 0, 1, 3, 0);
    hold(2, 1, 1, 3, 0);
    cyc(0, 0, 0, 1, 1, 1, 3, 0);
    hold(1, 0, 0, 0, 1);
    hold(1, 0, 0, 0, 0);
    mute = 1'b0;
`endif

    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
